rr_grant_encoder_ctrl: RTL



---
 rtl/rr_grant_encoder_ctrl_pkg.sv | 31 +++
 rtl/rr_grant_encoder_ctrl_if.sv | 25 ++
 rtl/rr_grant_encoder_ctrl_prio_select.sv | 37 +++
 rtl/rr_grant_encoder_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/rr_grant_encoder_ctrl_pkg.sv
// Shared types and helpers for the round-robin grant encoder/sequencer.
// The encoder mirrors the 32-to-5 one-hot OR-tree used elsewhere in the datapath.
package rr_grant_encoder_ctrl_pkg;

  localparam int MAX_N    = 32;
  localparam int MAX_IDXW = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    OWNED = 2'd2
  } state_e;

  // Index width for a requester count; a single-bit index is the floor.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // idx[k] is the OR of every one-hot bit whose position has bit k set.
  function automatic logic [MAX_IDXW-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [MAX_IDXW-1:0] idx;
    idx = '0;
    for (int k = 0; k < MAX_IDXW; k++) begin
      for (int i = 0; i < MAX_N; i++) begin
        if (i[k]) idx[k] = idx[k] | oh[i];
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_grant_encoder_ctrl_if.sv
// Requester/consumer-facing bundle of the grant sequencer.
// The arbiter is the slave side; requester front-ends and the slot consumer are the master.
interface rr_grant_encoder_ctrl_if #(
  parameter int N    = 32,
  parameter int IDXW = $clog2(N)
);
  logic [N-1:0]    req;
  logic            grant_valid;
  logic            grant_ready;
  logic [N-1:0]    grant_onehot;
  logic [IDXW-1:0] grant_idx;
  logic            busy;
  logic            owner_release;
  logic            timeout;

  modport master (
    output req, grant_ready, owner_release,
    input  grant_valid, grant_onehot, grant_idx, busy, timeout
  );

  modport slave (
    input  req, grant_ready, owner_release,
    output grant_valid, grant_onehot, grant_idx, busy, timeout
  );
endinterface

// File: rtl/rr_grant_encoder_ctrl_prio_select.sv
// Combinational rotating priority select: first set req bit at or after ptr, wrapping.
// Masked pass covers [ptr, N-1]; unmasked pass supplies the wrap into [0, ptr-1].
module rr_prio_select
  import rr_grant_encoder_ctrl_pkg::*;
#(
  parameter int N    = 32,
  parameter int IDXW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic [N-1:0]    onehot,
  output logic [IDXW-1:0] idx,
  output logic            any
);
  logic [N-1:0]        mask;
  logic [N-1:0]        masked;
  logic [N-1:0]        pick_m;
  logic [N-1:0]        pick_u;
  logic [MAX_N-1:0]    oh_wide;
  logic [MAX_IDXW-1:0] idx_wide;

  for (genvar i = 0; i < N; i++) begin : g_mask
    assign mask[i] = (IDXW'(i) >= ptr);
  end

  assign masked = req & mask;
  // x & -x isolates the lowest set bit.
  assign pick_m = masked & (-masked);
  assign pick_u = req & (-req);
  assign onehot = (|masked) ? pick_m : pick_u;
  assign any    = |req;

  assign oh_wide  = MAX_N'(onehot);
  assign idx_wide = onehot_to_idx(oh_wide);
  assign idx      = idx_wide[IDXW-1:0];

endmodule

// File: rtl/rr_grant_encoder_ctrl.sv
// Round-robin arbiter/sequencer sharing one garbled-datapath slot among N requesters:
// selects, offers via valid/ready, then tracks ownership until release, drop or timeout.
module rr_grant_encoder_ctrl
  import rr_grant_encoder_ctrl_pkg::*;
#(
  parameter int N        = 32,
  parameter int IDXW     = $clog2(N),
  parameter int MAX_HOLD = 255,
  parameter int CNTW     = 8
) (
  input logic                   clk,
  input logic                   rst,
  rr_grant_encoder_ctrl_if.slave bus
);
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MAX_HOLD - 1);

  state_e          state, state_nxt;
  logic [IDXW-1:0] ptr, ptr_nxt;
  logic [CNTW-1:0] hold_cnt, hold_nxt;
  logic [N-1:0]    gnt_onehot;
  logic [IDXW-1:0] gnt_idx;
  logic            timeout_q, timeout_nxt;
  logic            load;

  logic [N-1:0]    sel_onehot;
  logic [IDXW-1:0] sel_idx;
  logic            sel_any;
  logic            req_held;

  rr_prio_select #(.N(N), .IDXW(IDXW)) u_sel (
    .req    (bus.req),
    .ptr    (ptr),
    .onehot (sel_onehot),
    .idx    (sel_idx),
    .any    (sel_any)
  );

  assign req_held = bus.req[gnt_idx];

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
    load        = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel_any) begin
          load      = 1'b1;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        // Withdrawal wins over acceptance and leaves ptr where it was.
        if (!req_held) begin
          state_nxt = IDLE;
        end else if (bus.grant_ready) begin
          state_nxt = OWNED;
          hold_nxt  = '0;
        end
      end
      OWNED: begin
        if (hold_cnt != '1) hold_nxt = hold_cnt + CNTW'(1);
        if (bus.owner_release || !req_held) begin
          state_nxt = IDLE;
          ptr_nxt   = gnt_idx + IDXW'(1);
        end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
          state_nxt   = IDLE;
          ptr_nxt     = gnt_idx + IDXW'(1);
          timeout_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      hold_cnt   <= '0;
      gnt_onehot <= '0;
      gnt_idx    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      timeout_q <= timeout_nxt;
      if (load) begin
        gnt_onehot <= sel_onehot;
        gnt_idx    <= sel_idx;
      end
    end
  end

  // Held grant registers are hidden while idle so the outputs read zero.
  assign bus.grant_valid  = (state == OFFER);
  assign bus.busy         = (state == OWNED);
  assign bus.grant_onehot = (state == IDLE) ? '0 : gnt_onehot;
  assign bus.grant_idx    = (state == IDLE) ? '0 : gnt_idx;
  assign bus.timeout      = timeout_q;

endmodule
